// File: rtl/mar_addr_gen.sv
// Memory address register with address generation: issues mar_q (or an indexed
// base+offset) over a valid/ready handshake, then optionally steps it inside a wrap window.
module mar_addr_gen #(
    parameter int              AW        = 13,
    parameter int              STRIDE_W  = 4,
    parameter logic [AW-1:0]   WIN_BASE  = 13'h0000,
    parameter logic [AW-1:0]   WIN_LIMIT = 13'h1FFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_mar,
    input  logic [AW-1:0]       in_mar,
    input  logic                re_en_mar,
    input  logic [1:0]          mode,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [AW-1:0]       offset,
    input  logic                mem_ready,
    output logic [AW-1:0]       ou_mar,
    output logic                ou_valid,
    output logic                busy,
    output logic [AW-1:0]       mar_q,
    output logic                wrap_flag,
    input  logic                clr_wrap
);
    localparam logic [AW:0]   WSIZE   = {1'b0, WIN_LIMIT} - {1'b0, WIN_BASE} + 1'b1;
    // Reduction subtracts WSIZE modulo 2^AW, so only its low AW bits matter.
    localparam logic [AW-1:0] WSIZE_L = WSIZE[AW-1:0];
    localparam logic [1:0]    M_INC   = 2'b01;
    localparam logic [1:0]    M_DEC   = 2'b10;
    localparam logic [1:0]    M_IDX   = 2'b11;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_mode;
    logic [STRIDE_W-1:0]   r_stride;
    logic [AW-1:0]         r_mar, r_ou_mar;
    logic                  r_ou_valid, r_wrap;

    logic                  w_start, w_load, w_done;
    logic [AW:0]           w_stride_x, w_sum, w_inc;
    logic [AW-1:0]         w_ea, w_upd;
    logic                  w_wrap_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (re_en_mar) w_next = S_ISSUE;
            S_ISSUE: if (mem_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == S_ISSUE);
        w_start = (r_state == S_IDLE) && re_en_mar;
        w_load  = (r_state == S_IDLE) && !re_en_mar && wr_en_mar;
        w_done  = (r_state == S_ISSUE) && mem_ready;
    end

    // Effective address for the issue cycle
    always_comb begin
        w_sum = {1'b0, r_mar} + {1'b0, offset};
        w_ea  = r_mar;
        if (mode == M_IDX)
            w_ea = (w_sum > {1'b0, WIN_LIMIT}) ? (w_sum[AW-1:0] - WSIZE_L) : w_sum[AW-1:0];
    end

    // Post-update from the mode/stride latched at issue
    always_comb begin
        w_stride_x = {{(AW+1-STRIDE_W){1'b0}}, r_stride};
        w_inc      = {1'b0, r_mar} + w_stride_x;
        w_upd      = r_mar;
        w_wrap_evt = 1'b0;
        if (r_stride != '0) begin
            if (r_mode == M_INC) begin
                w_wrap_evt = (w_inc > {1'b0, WIN_LIMIT});
                w_upd      = w_wrap_evt ? (w_inc[AW-1:0] - WSIZE_L) : w_inc[AW-1:0];
            end else if (r_mode == M_DEC) begin
                w_wrap_evt = ({1'b0, r_mar} < ({1'b0, WIN_BASE} + w_stride_x));
                w_upd      = r_mar - w_stride_x[AW-1:0] + (w_wrap_evt ? WSIZE_L : '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mar      <= WIN_BASE;
            r_ou_mar   <= '0;
            r_ou_valid <= 1'b0;
            r_mode     <= '0;
            r_stride   <= '0;
        end else if (w_start) begin
            r_ou_mar   <= w_ea;
            r_ou_valid <= 1'b1;
            r_mode     <= mode;
            r_stride   <= stride;
        end else if (w_load) begin
            r_mar      <= in_mar;
        end else if (w_done) begin
            r_ou_valid <= 1'b0;
            r_mar      <= w_upd;
        end
    end

    // A wrap in the same cycle as clr_wrap wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_wrap <= 1'b0;
        else if (w_done && w_wrap_evt) r_wrap <= 1'b1;
        else if (clr_wrap)            r_wrap <= 1'b0;
    end

    assign ou_mar    = r_ou_mar;
    assign ou_valid  = r_ou_valid;
    assign mar_q     = r_mar;
    assign wrap_flag = r_wrap;
endmodule

// File: tb/tb_mar_addr_gen.sv
// Bench for mar_addr_gen: issued addresses go through a scoreboard queue checked by a
// handshake monitor; register/flag state is checked directly against hand-computed values.
module tb_mar_addr_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en_mar, re_en_mar, mem_ready, clr_wrap;
    logic [12:0] in_mar, offset;
    logic [1:0]  mode;
    logic [3:0]  stride;
    logic [12:0] ou_mar, mar_q;
    logic        ou_valid, busy, wrap_flag;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [12:0] exp_q[$];

    mar_addr_gen #(.AW(13), .STRIDE_W(4), .WIN_BASE(13'h0100), .WIN_LIMIT(13'h01FF)) dut (
        .clk(clk), .rst(rst), .wr_en_mar(wr_en_mar), .in_mar(in_mar),
        .re_en_mar(re_en_mar), .mode(mode), .stride(stride), .offset(offset),
        .mem_ready(mem_ready), .ou_mar(ou_mar), .ou_valid(ou_valid), .busy(busy),
        .mar_q(mar_q), .wrap_flag(wrap_flag), .clr_wrap(clr_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected address
    always @(negedge clk) begin
        if (!rst && ou_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_xfer: got %0h expected none", ou_mar);
            end else begin
                chk("sb_addr", ou_mar, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic load(input logic [12:0] v);
        @(posedge clk); #1;
        wr_en_mar = 1'b1; in_mar = v;
        @(posedge clk); #1;
        wr_en_mar = 1'b0;
        @(negedge clk);
        chk("load_mar", mar_q, v);
        chk("load_valid", ou_valid, 0);
    endtask

    task automatic clr();
        @(posedge clk); #1;
        clr_wrap = 1'b1;
        @(posedge clk); #1;
        clr_wrap = 1'b0;
        @(negedge clk);
        chk("clr_wrap", wrap_flag, 0);
    endtask

    // One transfer; poke keeps wr_en/re_en high through ISSUE, clr_done pulses clr_wrap on the accept cycle
    task automatic xfer(input logic [1:0] m, input logic [3:0] s, input logic [12:0] off,
                        input logic [12:0] ea, input int nwait, input bit poke, input bit clr_done,
                        input logic [12:0] exp_mar, input logic exp_wrap, input string nm);
        @(posedge clk); #1;
        re_en_mar = 1'b1; mode = m; stride = s; offset = off;
        if (poke) begin wr_en_mar = 1'b1; in_mar = 13'h0AAA; end
        exp_q.push_back(ea);
        @(posedge clk); #1;
        re_en_mar = poke; mode = ~m; stride = ~s; offset = ~off;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, ou_valid, 1);
            chk({nm, "_hold_addr"}, ou_mar, ea);
            chk({nm, "_hold_busy"}, busy, 1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; re_en_mar = 1'b0; wr_en_mar = 1'b0; clr_wrap = clr_done;
        @(negedge clk);
        chk({nm, "_valid_at_accept"}, ou_valid, 1);
        @(posedge clk); #1;
        mem_ready = 1'b0; clr_wrap = 1'b0;
        @(negedge clk);
        chk({nm, "_valid_after"}, ou_valid, 0);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_mar"}, mar_q, exp_mar);
        chk({nm, "_wrap"}, wrap_flag, exp_wrap);
        chk({nm, "_ou_mar_kept"}, ou_mar, ea);
    endtask

    initial begin
        rst = 1'b1; wr_en_mar = 1'b0; re_en_mar = 1'b0; mem_ready = 1'b0; clr_wrap = 1'b0;
        in_mar = '0; offset = '0; mode = '0; stride = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mar", mar_q, 13'h0100);
        chk("rst_ou_mar", ou_mar, 0);
        chk("rst_valid", ou_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap_flag, 0);

        // Async reset mid-cycle, observed before any clock edge
        load(13'h0055);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_mar", mar_q, 13'h0100);
        chk("async_rst_valid", ou_valid, 0);
        @(posedge clk); #1 rst = 1'b0;

        load(13'h0123);
        xfer(2'b01, 4'd4, 13'h0, 13'h0123, 3, 0, 0, 13'h0127, 0, "inc");

        load(13'h01FE);
        xfer(2'b01, 4'd3, 13'h0, 13'h01FE, 1, 0, 0, 13'h0101, 1, "incwrap");
        clr();

        load(13'h0102);
        xfer(2'b10, 4'd5, 13'h0, 13'h0102, 2, 0, 0, 13'h01FD, 1, "decwrap");
        clr();
        xfer(2'b01, 4'd4, 13'h0, 13'h01FD, 0, 0, 1, 13'h0101, 1, "wrap_vs_clr");
        clr();

        load(13'h01F0);
        xfer(2'b11, 4'd0, 13'h0020, 13'h0110, 1, 0, 0, 13'h01F0, 0, "idxwrap");
        xfer(2'b01, 4'd1, 13'h0, 13'h01F0, 2, 1, 0, 13'h01F1, 0, "prio");
        xfer(2'b01, 4'd0, 13'h0, 13'h01F1, 0, 0, 0, 13'h01F1, 0, "stride0");
        xfer(2'b11, 4'd2, 13'h0005, 13'h01F6, 0, 0, 0, 13'h01F1, 0, "idx");

        // Reset while ISSUE is pending aborts the transfer
        @(posedge clk); #1;
        re_en_mar = 1'b1; mode = 2'b01; stride = 4'd2;
        @(posedge clk); #1;
        re_en_mar = 1'b0;
        @(negedge clk);
        chk("abort_pre_valid", ou_valid, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort_valid", ou_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mar", mar_q, 13'h0100);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_after_valid", ou_valid, 0);
        chk("abort_after_mar", mar_q, 13'h0100);

        repeat (2) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mar_addr_gen.md
Name: mar_addr_gen

Overview:
Parametrised memory address register with an address-generation unit. It holds a base address written by the datapath. On a read request it issues an address to memory over a valid/ready handshake. After each completed transfer it can post-increment or post-decrement the held address by a programmable stride, wrapping inside a configured address window. An indexed mode issues base+offset without modifying the register.

Parameters:
AW, 13, address width in bits.
STRIDE_W, 4, width of the stride input.
WIN_BASE, 13'h0000, lowest address of the wrap window (AW bits).
WIN_LIMIT, 13'h1FFF, highest address of the wrap window, inclusive; WIN_LIMIT >= WIN_BASE.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
wr_en_mar  in  1  load in_mar into the address register.
in_mar  in  AW  address to load.
re_en_mar  in  1  request: issue an address to memory.
mode  in  2  00 hold, 01 post-increment, 10 post-decrement, 11 indexed.
stride  in  STRIDE_W  post-update step, unsigned.
offset  in  AW  index offset for mode 11, unsigned.
mem_ready  in  1  memory accepts ou_mar this cycle.
ou_mar  out  AW  issued address, registered.
ou_valid  out  1  ou_mar is valid and awaiting mem_ready.
busy  out  1  high while in ISSUE.
mar_q  out  AW  current address register contents, for debug.
wrap_flag  out  1  sticky flag: a post-update wrapped.
clr_wrap  in  1  clear wrap_flag.

Behaviour:
- Reset (async, immediate):
  - mar_q = WIN_BASE.
  - ou_mar = 0.
  - ou_valid = 0.
  - busy = 0.
  - wrap_flag = 0.
  - FSM = IDLE.
  - Reset while in ISSUE aborts the transfer; no post-update occurs.
- FSM states are IDLE and ISSUE. busy = (state == ISSUE).
- IDLE, priority re_en_mar > wr_en_mar:
  - re_en_mar = 1: latch mode and stride. Set ou_mar = EA, ou_valid = 1, go to ISSUE. A simultaneous wr_en_mar is dropped.
  - else wr_en_mar = 1: mar_q <= in_mar, loaded as-is with no window check. ou_valid stays 0.
- Effective address EA:
  - Modes 00, 01, 10: EA = mar_q.
  - Mode 11: s = mar_q + offset, computed in AW+1 bits. If s > WIN_LIMIT then EA = s - WSIZE, else EA = s.
  - WSIZE = WIN_LIMIT - WIN_BASE + 1.
  - offset < WSIZE is required by the user; no multiple-wrap handling.
- ISSUE:
  - ou_mar and ou_valid are held stable until mem_ready = 1.
  - wr_en_mar and re_en_mar are ignored. Offset and stride changes have no effect.
  - On the mem_ready cycle: ou_valid <= 0, apply the post-update using the latched mode/stride, go to IDLE.
  - ou_mar keeps its last value after completion.
  - Minimum one IDLE cycle between transfers.
- Post-update, using the latched mode and stride:
  - 00 and 11: mar_q unchanged.
  - 01: n = mar_q + stride in AW+1 bits.
    - If n > WIN_LIMIT: mar_q <= n - WSIZE, wrap event.
    - Else mar_q <= n.
  - 10:
    - If mar_q < WIN_BASE + stride: mar_q <= mar_q - stride + WSIZE, wrap event.
    - Else mar_q <= mar_q - stride.
  - stride = 0: no change and no wrap.
  - stride <= WSIZE is required.
- wrap_flag:
  - Set on any wrap event; stays set until clr_wrap.
  - A set and clr_wrap in the same cycle leaves wrap_flag = 1.
  - clr_wrap is honoured in any state.
- All arithmetic is unsigned. Internal sums are AW+1 bits; results are truncated to AW after reduction.

Test Plan:
Common setup for all cases: AW=13, WIN_BASE=13'h0100, WIN_LIMIT=13'h01FF.
- Reset/load: assert rst mid-cycle -> outputs zero at once and mar_q = 0x0100 without a clock edge. Then wr_en_mar with in_mar = 0x0123 -> mar_q = 0x0123 next edge, ou_valid = 0.
- Handshake and post-inc: mar_q = 0x0123, re_en_mar, mode 01, stride 4, mem_ready held low for 3 cycles -> ou_mar = 0x0123 with ou_valid = 1 held for 3 cycles. On mem_ready -> ou_valid = 0, mar_q = 0x0127, wrap_flag = 0.
- Increment wrap: mar_q = 0x01FE, mode 01, stride 3 -> ou_mar = 0x01FE, then mar_q = 0x0101, wrap_flag = 1. clr_wrap -> 0.
- Decrement wrap: mar_q = 0x0102, mode 10, stride 5 -> mar_q = 0x01FD, wrap_flag = 1. Apply a wrap and clr_wrap in the same cycle -> wrap_flag stays 1.
- Indexed: mar_q = 0x01F0, mode 11, offset 0x0020 -> ou_mar = 0x0110, mar_q stays 0x01F0, wrap_flag unchanged.
- Priority and abort:
  - re_en_mar and wr_en_mar together in IDLE -> issue uses the old mar_q and the load is dropped.
  - wr_en_mar during ISSUE -> ignored.
  - rst during ISSUE -> ou_valid = 0 immediately, mar_q = 0x0100.
